// File: rtl/sar_adc_ctrl.sv
// Controller-side sequencer for a 10-bit SAR ADC macro: power-up calibration,
// periodic conversions, 2^AVG_LOG2 averaging and a valid/ready sample output.
module sar_adc_ctrl #(
  parameter int CAL_CYCLES = 64,
  parameter int TIMEOUT    = 31,
  parameter int AVG_LOG2   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        cal_req,
  input  logic [15:0] period,
  input  logic        clr_flags,
  output logic        adc_en,
  output logic        adc_cal,
  input  logic        adc_valid,
  input  logic [9:0]  adc_result,
  output logic [9:0]  sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  localparam int ACC_W = 10 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int CAL_W = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] AVG_N    = CNT_W'(2 ** AVG_LOG2);
  localparam logic [CAL_W-1:0] CAL_LOAD = CAL_W'(CAL_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CAL, ST_WAIT, ST_CONV} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic               pend_q, pend_d;
  logic               cal_done_q, cal_done_d;
  logic [CAL_W-1:0]   cal_cnt_q, cal_cnt_d;
  logic [15:0]        per_cnt_q, per_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               adc_en_q, adc_en_d;
  logic               adc_cal_q, adc_cal_d;
  logic               busy_q, busy_d;

  logic               capture, offer, ovr_set, tmo_set;
  logic [9:0]         avg;

  always_comb begin
    state_d    = state_q;
    sync1_d    = adc_valid;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    pend_d     = pend_q | cal_req;
    cal_done_d = cal_done_q;
    cal_cnt_d  = cal_cnt_q;
    per_cnt_d  = per_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    capture    = 1'b0;
    ovr_set    = 1'b0;
    tmo_set    = 1'b0;

    // A full set was counted last cycle: hand its average out and restart.
    offer = (cnt_q == AVG_N);
    avg   = acc_q[AVG_LOG2 +: 10];
    if (offer) begin
      acc_d = '0;
      cnt_d = '0;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cal_done_q || pend_q) begin
            state_d   = ST_CAL;
            cal_cnt_d = CAL_LOAD;
          end else begin
            state_d   = ST_WAIT;
            per_cnt_d = period;
          end
        end
        ST_CAL: begin
          if (cal_cnt_q == '0) begin
            state_d    = ST_WAIT;
            per_cnt_d  = period;
            cal_done_d = 1'b1;
            pend_d     = cal_req;
          end else begin
            cal_cnt_d = cal_cnt_q - CAL_W'(1);
          end
        end
        // WAIT lasts max(period,1) cycles; a pending recal preempts it.
        ST_WAIT: begin
          if (pend_q) begin
            state_d   = ST_CAL;
            cal_cnt_d = CAL_LOAD;
          end else if (per_cnt_q <= 16'd1) begin
            state_d   = ST_CONV;
            tmo_cnt_d = TMO_LOAD;
          end else begin
            per_cnt_d = per_cnt_q - 16'd1;
          end
        end
        ST_CONV: begin
          capture = sync2_q & ~sync3_q;
          if (capture) begin
            acc_d     = acc_q + ACC_W'(adc_result);
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = ST_WAIT;
            per_cnt_d = period;
          end else if (tmo_cnt_q == '0) begin
            tmo_set   = 1'b1;
            state_d   = ST_WAIT;
            per_cnt_d = period;
          end else begin
            tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (offer) begin
      if (!valid_q || sample_ready) begin
        data_d  = avg;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    overrun_d = ovr_set | (overrun_q & ~clr_flags);
    timeout_d = tmo_set | (timeout_q & ~clr_flags);

    adc_en_d  = (state_d == ST_CAL) || (state_d == ST_CONV);
    adc_cal_d = (state_d == ST_CAL);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      pend_q     <= 1'b0;
      cal_done_q <= 1'b0;
      cal_cnt_q  <= '0;
      per_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      adc_en_q   <= 1'b0;
      adc_cal_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      pend_q     <= pend_d;
      cal_done_q <= cal_done_d;
      cal_cnt_q  <= cal_cnt_d;
      per_cnt_q  <= per_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      adc_en_q   <= adc_en_d;
      adc_cal_q  <= adc_cal_d;
      busy_q     <= busy_d;
    end
  end

  assign adc_en       = adc_en_q;
  assign adc_cal      = adc_cal_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ADC macro model, averaging scoreboard checked every
// cycle the output is valid, and directed timing/flag checks.
module tb_sar_adc_ctrl;

  localparam int ADC_DLY = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        cal_req;
  logic [15:0] period;
  logic        clr_flags;
  logic        adc_en;
  logic        adc_cal;
  logic        adc_valid;
  logic [9:0]  adc_result;
  logic [9:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // ADC stimulus values, the open averaging group and expected outputs
  int unsigned vq[$];
  int unsigned grp[$];
  int unsigned exp_q[$];
  int          drops  = 0;
  int          pops   = 0;
  int          dflt_k = 0;
  bit          respond = 1'b1;

  sar_adc_ctrl #(.CAL_CYCLES(64), .TIMEOUT(31), .AVG_LOG2(2)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .cal_req(cal_req),
    .period(period), .clr_flags(clr_flags), .adc_en(adc_en), .adc_cal(adc_cal),
    .adc_valid(adc_valid), .adc_result(adc_result), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic creq, input logic [15:0] per,
                               input logic clr, input logic rdy);
    enable       = en;
    cal_req      = creq;
    period       = per;
    clr_flags    = clr;
    sample_ready = rdy;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // A completed group of four yields floor(sum/4); it is dropped if the
  // previous average is still waiting for the consumer.
  task automatic model_capture(input int unsigned v);
    int unsigned sum;
    grp.push_back(v);
    if (grp.size() == 4) begin
      sum = 0;
      foreach (grp[i]) sum += grp[i];
      if (exp_q.size() == 0) exp_q.push_back(sum / 4);
      else drops++;
      grp.delete();
    end
  endtask

  // ADC macro: once enabled for conversion, raise valid after ADC_DLY cycles
  // and hold it with a stable result until en drops.
  initial begin
    int dly;
    int unsigned v;
    adc_valid  = 1'b0;
    adc_result = '0;
    dly        = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn || !adc_en || adc_cal) begin
        adc_valid = 1'b0;
        dly       = 0;
      end else if (respond && !adc_valid) begin
        dly++;
        if (dly >= ADC_DLY) begin
          if (vq.size() > 0) v = vq.pop_front();
          else begin
            v = 300 + (dflt_k * 37) % 400;
            dflt_k++;
          end
          adc_result = v[9:0];
          adc_valid  = 1'b1;
          model_capture(v);
        end
      end
    end
  end

  // Every valid output cycle must present the scoreboard's head value.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b1) begin
        if (adc_cal) checkOutput("cal_implies_en", adc_en, 1);
        if (sample_valid) begin
          if (exp_q.size() == 0) checkOutput("unexpected_sample", sample_valid, 0);
          else begin
            checkOutput("sample_data_model", sample_data, exp_q[0]);
            if (sample_ready) begin
              void'(exp_q.pop_front());
              pops++;
            end
          end
        end
      end
    end
  end

  function automatic bit cond(input int m);
    case (m)
      0: return adc_cal;
      1: return adc_en && !adc_cal;
      2: return sample_valid;
      3: return !adc_en;
      4: return overrun;
      5: return grp.size() == 2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int m, input int max_cycles, input string what);
    int n = 0;
    while (!cond(m) && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput(what, cond(m), 1);
  endtask

  task automatic count_cal(input string what);
    int n = 0;
    while (adc_cal && n < 1000) begin
      n++;
      step();
    end
    checkOutput(what, n, 64);
  endtask

  task automatic count_idle_en(input string what, input int exp);
    int n = 0;
    while (!adc_en && n < 1000) begin
      n++;
      step();
    end
    checkOutput(what, n, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_adc_en"}, adc_en, 0);
    checkOutput({tag, "_adc_cal"}, adc_cal, 0);
    checkOutput({tag, "_sample_valid"}, sample_valid, 0);
    checkOutput({tag, "_sample_data"}, sample_data, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int n;
    int cal_seen;
    bit seen;
    int old_pops;

    rstn = 1'b0;
    applyStimulus(0, 0, 16'd10, 0, 0);
    repeat (3) step();
    check_reset_outputs("reset");

    // Power-up calibration, then averaging of 100,101,102,104 -> 407>>2 = 101
    vq = '{100, 101, 102, 104};
    applyStimulus(1, 0, 16'd10, 0, 0);
    rstn = 1'b1;
    wait_until(0, 10, "cal_start");
    count_cal("cal_length");
    checkOutput("post_cal_busy", busy, 1);
    checkOutput("post_cal_en_low", adc_en, 0);
    count_idle_en("wait_gap_after_cal", 10);
    wait_until(3, 40, "conv1_end");
    count_idle_en("wait_gap_after_conv", 10);
    wait_until(2, 600, "first_avg_valid");
    checkOutput("first_avg_data", sample_data, 101);
    repeat (5) step();
    checkOutput("avg_held_valid", sample_valid, 1);
    checkOutput("avg_held_data", sample_data, 101);
    sample_ready = 1'b1;
    step();
    step();
    checkOutput("valid_cleared_by_handshake", sample_valid, 0);

    // Overrun with a stalled consumer, then clear
    sample_ready = 1'b0;
    wait_until(2, 600, "ovr_first_valid");
    wait_until(4, 600, "overrun_set");
    checkOutput("overrun_drops_model", drops, 1);
    sample_ready = 1'b1;
    step();
    step();
    checkOutput("ovr_valid_cleared", sample_valid, 0);
    checkOutput("overrun_sticky", overrun, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checkOutput("overrun_cleared", overrun, 0);

    // Set event wins over a clear held high in the same cycle
    sample_ready = 1'b0;
    clr_flags    = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 800) begin
      step();
      if (overrun) seen = 1'b1;
      n++;
    end
    checkOutput("overrun_set_beats_clr", seen, 1);
    step();
    checkOutput("overrun_clr_next", overrun, 0);
    clr_flags    = 1'b0;
    sample_ready = 1'b1;
    repeat (3) step();

    // Timeout: ADC stops answering for one conversion
    wait_until(1, 200, "tmo_prev_conv");
    wait_until(3, 50, "tmo_prev_conv_end");
    respond = 1'b0;
    wait_until(1, 50, "tmo_conv_start");
    n = 0;
    while (adc_en && n < 100) begin
      n++;
      step();
    end
    checkOutput("timeout_conv_length", n, 31);
    checkOutput("timeout_flag", timeout, 1);
    checkOutput("timeout_busy", busy, 1);
    respond = 1'b1;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checkOutput("timeout_cleared", timeout, 0);
    old_pops = pops;
    n = 0;
    while (pops == old_pops && n < 800) begin
      step();
      n++;
    end
    checkOutput("avg_after_timeout", pops, old_pops + 1);

    // Enable dropped after two captures: partial group discarded, no recal
    wait_until(5, 800, "two_captures");
    wait_until(3, 50, "second_capture_done");
    enable = 1'b0;
    grp.delete();
    vq = '{200, 201, 202, 203};
    repeat (3) step();
    checkOutput("disabled_busy", busy, 0);
    checkOutput("disabled_adc_en", adc_en, 0);
    enable = 1'b1;
    cal_seen = 0;
    n = 0;
    while (!sample_valid && n < 800) begin
      step();
      if (adc_cal) cal_seen++;
      n++;
    end
    checkOutput("reenable_no_cal", cal_seen, 0);
    checkOutput("fresh_avg_data", sample_data, 201);
    repeat (3) step();

    // cal_req during CONV: conversion completes, then recalibration
    wait_until(1, 200, "calreq_conv");
    cal_req = 1'b1;
    step();
    cal_req = 1'b0;
    wait_until(3, 50, "calreq_conv_done");
    n = 0;
    while (!adc_cal && n < 100) begin
      n++;
      step();
    end
    checkOutput("calreq_wait_before_cal", n, 1);
    count_cal("recal_length");
    count_idle_en("wait_gap_after_recal", 10);

    // Asynchronous reset in the middle of a conversion
    wait_until(1, 200, "rst_conv");
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    grp.delete();
    exp_q.delete();
    vq.delete();
    repeat (3) step();
    rstn = 1'b1;
    wait_until(0, 10, "cal_after_reset");
    count_cal("cal_after_reset_length");
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
